// File: rtl/stream_prefetcher_pkg.sv
// Shared definitions for the stream prefetcher, the stream buffer and the
// cache lookup logic: widths, packet layout and the prefetcher state type.
package stream_prefetcher_pkg;

    localparam int ADDR_W       = 28;
    localparam int DATA_W       = 128;
    localparam int PACKET_WIDTH = 1 + ADDR_W + DATA_W;

    // Packet layout: {valid, addr, data}, valid in the MSB, data in the LSBs.
    localparam int VALID_BIT = PACKET_WIDTH - 1;
    localparam int ADDR_MSB  = PACKET_WIDTH - 2;
    localparam int ADDR_LSB  = DATA_W;
    localparam int DATA_MSB  = DATA_W - 1;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REQ   = 2'd2,
        WRITE = 2'd3
    } state_e;

    function automatic logic [PACKET_WIDTH-1:0] make_packet(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, addr, data};
    endfunction

endpackage

// File: rtl/stream_prefetcher_if.sv
// Memory port and stream buffer write port of the prefetcher, bundled.
// master = prefetcher side, slave = memory / stream buffer side.
interface stream_prefetcher_if;
    import stream_prefetcher_pkg::*;

    logic                    mem_grant_i;
    logic                    mem_read_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic [DATA_W-1:0]       mem_rdata_i;
    logic                    mem_ready_i;
    logic                    sb_write_o;
    logic [PACKET_WIDTH-1:0] sb_packet_o;
    logic                    sb_full_i;

    modport master (
        input  mem_grant_i,
        output mem_read_o,
        output mem_addr_o,
        input  mem_rdata_i,
        input  mem_ready_i,
        output sb_write_o,
        output sb_packet_o,
        input  sb_full_i
    );

    modport slave (
        output mem_grant_i,
        input  mem_read_o,
        input  mem_addr_o,
        output mem_rdata_i,
        output mem_ready_i,
        input  sb_write_o,
        input  sb_packet_o,
        output sb_full_i
    );

endinterface

// File: rtl/stream_prefetcher_addr_gen.sv
// Next block address and fetched-block counter for one prefetch stream.
// load restarts the stream just after base_addr_i; inc advances one block.
module prefetch_addr_gen
    import stream_prefetcher_pkg::*;
#(
    parameter int FETCH_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] next_addr_d, next_addr_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    // Load wins over increment; both wrap naturally at their widths.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        next_addr_d = next_addr_q;
        cnt_d       = cnt_q;
        if (load_i) begin
            next_addr_d = base_addr_i + ADDR_W'(1);
            cnt_d       = '0;
        end else if (inc_i) begin
            next_addr_d = next_addr_q + ADDR_W'(1);
            cnt_d       = cnt_q + CNT_W'(1);
        end
    end

    // Address and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            next_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            next_addr_q <= next_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign next_addr_o = next_addr_q;
    assign done_o      = (cnt_q == CNT_W'(FETCH_DEPTH));

endmodule

// File: rtl/stream_prefetcher.sv
// Stream prefetcher: after a miss, reads FETCH_DEPTH sequential blocks from
// memory and writes each one into the stream buffer as a single packet.
module stream_prefetcher
    import stream_prefetcher_pkg::*;
#(
    parameter int FETCH_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          start_addr_i,
    input  logic                       flush_i,
    output logic                       busy_o,
    stream_prefetcher_if.master        bus
);

    state_e                  state_d, state_q;
    logic                    drop_d, drop_q;
    logic                    restart_d, restart_q;
    logic [ADDR_W-1:0]       pend_addr_d, pend_addr_q;
    logic                    mem_read_d, mem_read_q;
    logic [ADDR_W-1:0]       mem_addr_d, mem_addr_q;
    logic                    sb_write_d, sb_write_q;
    logic [PACKET_WIDTH-1:0] packet_d, packet_q;
    logic                    busy_d, busy_q;

    logic                    ag_load, ag_inc, ag_done;
    logic [ADDR_W-1:0]       ag_base, ag_next;
    logic                    drop_now, restart_now;

    prefetch_addr_gen #(
        .FETCH_DEPTH (FETCH_DEPTH),
        .CNT_W       (CNT_W)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (ag_load),
        .base_addr_i (ag_base),
        .inc_i       (ag_inc),
        .next_addr_o (ag_next),
        .done_o      (ag_done)
    );

    // A start or flush landing in the response cycle already dooms that data;
    // a later flush cancels a restart that is still waiting for the drain.
    assign drop_now    = drop_q | start_i | flush_i;
    assign restart_now = start_i | (restart_q & ~flush_i);

    // Next-state and next-output logic of the prefetch FSM.
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        restart_d   = restart_q;
        pend_addr_d = pend_addr_q;
        mem_read_d  = mem_read_q;
        mem_addr_d  = mem_addr_q;
        sb_write_d  = 1'b0;
        packet_d    = packet_q;
        ag_load     = 1'b0;
        ag_base     = start_addr_i;
        ag_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ag_load = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (start_i) begin
                    ag_load = 1'b1;
                end else if (flush_i || ag_done) begin
                    state_d = IDLE;
                end else if (bus.mem_grant_i && !bus.sb_full_i) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = ag_next;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // The request is never withdrawn; aborts only mark the data dead.
                if (start_i) begin
                    pend_addr_d = start_addr_i;
                    restart_d   = 1'b1;
                    drop_d      = 1'b1;
                end else if (flush_i) begin
                    restart_d = 1'b0;
                    drop_d    = 1'b1;
                end
                if (bus.mem_ready_i) begin
                    mem_read_d = 1'b0;
                    drop_d     = 1'b0;
                    restart_d  = 1'b0;
                    if (!drop_now) begin
                        packet_d   = make_packet(mem_addr_q, bus.mem_rdata_i);
                        sb_write_d = 1'b1;
                        state_d    = WRITE;
                    end else if (restart_now) begin
                        ag_load = 1'b1;
                        ag_base = pend_addr_d;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (start_i) begin
                    ag_load = 1'b1;
                    state_d = WAIT;
                end else if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    ag_inc  = 1'b1;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            restart_q   <= 1'b0;
            pend_addr_q <= '0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            sb_write_q  <= 1'b0;
            // NOTE: the packet/data register is reset too, so sb_packet_o is
            // defined from reset instead of holding X until the first write.
            packet_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            restart_q   <= restart_d;
            pend_addr_q <= pend_addr_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
            sb_write_q  <= sb_write_d;
            packet_q    <= packet_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_read_o  = mem_read_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.sb_packet_o = packet_q;
    // NOTE: the write strobe is gated combinationally: the buffer drops writes
    // in its flush cycle, which is only known in the WRITE cycle itself.
    assign bus.sb_write_o  = sb_write_q & ~flush_i & ~start_i;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_stream_prefetcher.sv
// Self-checking bench for stream_prefetcher: a memory responder, a bus
// monitor, and scenario tasks compared against an address-arithmetic model.
module tb_stream_prefetcher;
    import stream_prefetcher_pkg::*;

    localparam int FETCH_DEPTH = 4;

    logic              clk_i        = 1'b0;
    logic              rst_ni       = 1'b0;
    logic              start_i      = 1'b0;
    logic              flush_i      = 1'b0;
    logic [ADDR_W-1:0] start_addr_i = '0;
    logic              busy_o;

    int errors = 0;
    int checks = 0;

    stream_prefetcher_if bus ();

    stream_prefetcher #(
        .FETCH_DEPTH (FETCH_DEPTH),
        .CNT_W       (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .bus          (bus)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    bit [31:0] seed;
    int        mem_lat = 2;
    bit        spur_en = 1'b0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [31:0] a32;
        a32 = {4'h0, a};
        return {a32 * 32'h9E3779B1, ~a32, seed, a32 ^ seed};
    endfunction

    // i-th block of a stream started on a miss at base, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base, input int i);
        return ADDR_W'((longint'(base) + 1 + i) % (longint'(1) << ADDR_W));
    endfunction

    function automatic logic [PACKET_WIDTH-1:0] exp_pkt(input logic [ADDR_W-1:0] a);
        return {1'b1, a, mem_word(a)};
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            bus.mem_ready_i = 1'b0;
            if (bus.mem_read_o) begin
                if (lat_cnt >= mem_lat) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rdata_i = mem_word(bus.mem_addr_o);
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
                if (spur_en && $urandom_range(3) == 0) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rdata_i = {4{$urandom}};
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int                      cyc = 0;
    logic [ADDR_W-1:0]       req_q[$];
    int                      req_cyc_q[$];
    logic [PACKET_WIDTH-1:0] wr_q[$];
    int                      withdrawn = 0;
    int                      hold_err  = 0;
    int                      proto_err = 0;
    logic                    prev_read  = 1'b0;
    logic                    prev_ready = 1'b0;
    logic [ADDR_W-1:0]       prev_addr  = '0;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (bus.mem_read_o && !prev_read) begin
            req_q.push_back(bus.mem_addr_o);
            req_cyc_q.push_back(cyc);
        end
        if (prev_read && bus.mem_read_o && bus.mem_addr_o !== prev_addr) hold_err++;
        if (prev_read && !bus.mem_read_o && !prev_ready) withdrawn++;
        if (bus.sb_write_o) wr_q.push_back(bus.sb_packet_o);
        assert (!(bus.sb_write_o && bus.sb_full_i))
        else begin
            proto_err++;
            $error("FAIL protocol: sb_write_o=1 while sb_full_i=1");
        end
        prev_read  = bus.mem_read_o;
        prev_ready = bus.mem_ready_i;
        prev_addr  = bus.mem_addr_o;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a);
        start_addr_i = a;
        start_i      = 1'b1;
        step();
        start_i      = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (busy_o && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy_o=%b after %0d cycles, required 0", tag, busy_o, n);
        end
        step();
    endtask

    task automatic wait_read(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!bus.mem_read_o && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (bus.mem_read_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_no_request: mem_read_o=%b after %0d cycles, required 1", tag, bus.mem_read_o, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step();
        step();
        checks += 5;
        if (bus.mem_read_o !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b, required 0", bus.mem_read_o); end
        if (bus.sb_write_o !== 1'b0) begin errors++; $display("FAIL reset_sb_write: got %b, required 0", bus.sb_write_o); end
        if (busy_o !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
        if (bus.mem_addr_o !== '0)   begin errors++; $display("FAIL reset_mem_addr: got %h, required 0", bus.mem_addr_o); end
        if (bus.sb_packet_o !== '0)  begin errors++; $display("FAIL reset_packet: got %h, required 0", bus.sb_packet_o); end
        #3 rst_ni = 1'b1;
        step();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b, required 0", busy_o); end
    endtask

    task automatic test_basic_stream();
        int rb, wb, wd;
        logic [ADDR_W-1:0] base;
        base = 28'h0000010;
        mem_lat = 2;
        rb = req_q.size(); wb = wr_q.size(); wd = withdrawn + hold_err;
        pulse_start(base);
        wait_idle(200, "basic");
        checks += 4;
        if (req_q.size() - rb != FETCH_DEPTH) begin errors++; $display("FAIL basic_req_count: got %0d, required %0d", req_q.size() - rb, FETCH_DEPTH); end
        if (wr_q.size() - wb != FETCH_DEPTH)  begin errors++; $display("FAIL basic_wr_count: got %0d, required %0d", wr_q.size() - wb, FETCH_DEPTH); end
        if (withdrawn + hold_err != wd)       begin errors++; $display("FAIL basic_req_hold: %0d unstable requests, required 0", withdrawn + hold_err - wd); end
        if (bus.sb_packet_o !== exp_pkt(exp_addr(base, FETCH_DEPTH - 1)))
            begin errors++; $display("FAIL basic_packet_hold: got %h, required %h", bus.sb_packet_o, exp_pkt(exp_addr(base, FETCH_DEPTH - 1))); end
        for (int i = 0; i < FETCH_DEPTH && rb + i < req_q.size(); i++) begin
            checks++;
            if (req_q[rb + i] !== exp_addr(base, i))
                begin errors++; $display("FAIL basic_req_addr[%0d]: got %h, required %h", i, req_q[rb + i], exp_addr(base, i)); end
        end
        for (int i = 0; i < FETCH_DEPTH && wb + i < wr_q.size(); i++) begin
            checks += 2;
            if (wr_q[wb + i][VALID_BIT] !== 1'b1)
                begin errors++; $display("FAIL basic_valid[%0d]: got %b, required 1", i, wr_q[wb + i][VALID_BIT]); end
            if (wr_q[wb + i] !== exp_pkt(exp_addr(base, i)))
                begin errors++; $display("FAIL basic_packet[%0d]: got %h, required %h", i, wr_q[wb + i], exp_pkt(exp_addr(base, i))); end
        end
    endtask

    task automatic test_backpressure();
        int rb, wb, n, high, drop_cyc;
        logic [ADDR_W-1:0] base;
        base = 28'h0000010;
        mem_lat = 2;
        rb = req_q.size(); wb = wr_q.size();
        pulse_start(base);
        n = 0;
        while (wr_q.size() - wb < 2 && n < 100) begin step(); n++; end
        bus.sb_full_i = 1'b1;
        high = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_read_o) high++;
        end
        bus.sb_full_i = 1'b0;
        drop_cyc = cyc;
        wait_idle(200, "bp");
        checks += 4;
        if (high != 0) begin errors++; $display("FAIL bp_read_while_full: mem_read_o high %0d cycles, required 0", high); end
        if (req_q.size() - rb != FETCH_DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d, required %0d", req_q.size() - rb, FETCH_DEPTH); end
        if (wr_q.size() - wb != FETCH_DEPTH)  begin errors++; $display("FAIL bp_wr_count: got %0d, required %0d", wr_q.size() - wb, FETCH_DEPTH); end
        if (req_q.size() - rb > 2 && (req_q[rb + 2] !== exp_addr(base, 2) || req_cyc_q[rb + 2] != drop_cyc + 1))
            begin errors++; $display("FAIL bp_third_req: addr %h at cycle %0d, required %h at cycle %0d", req_q[rb + 2], req_cyc_q[rb + 2], exp_addr(base, 2), drop_cyc + 1); end
        else if (req_q.size() - rb <= 2)
            begin errors++; $display("FAIL bp_third_req: only %0d requests, required a third", req_q.size() - rb); end
    endtask

    task automatic test_grant_gating();
        int rb, wb, wd, high, g_cyc;
        logic [ADDR_W-1:0] base;
        base = 28'h0000040;
        mem_lat = 4;
        rb = req_q.size(); wb = wr_q.size(); wd = withdrawn + hold_err;
        bus.mem_grant_i = 1'b0;
        pulse_start(base);
        high = 0;
        for (int i = 0; i < 5; i++) begin step(); if (bus.mem_read_o) high++; end
        bus.mem_grant_i = 1'b1;
        g_cyc = cyc;
        wait_read(10, "grant");
        bus.mem_grant_i = 1'b0;
        for (int i = 0; i < 20 && wr_q.size() == wb; i++) step();
        for (int i = 0; i < 5; i++) begin step(); if (bus.mem_read_o) high++; end
        checks += 4;
        if (high != 0) begin errors++; $display("FAIL grant_read_without_grant: mem_read_o high %0d cycles, required 0", high); end
        if (req_q.size() - rb != 1 || wr_q.size() - wb != 1)
            begin errors++; $display("FAIL grant_held_request: %0d requests %0d writes, required 1 and 1", req_q.size() - rb, wr_q.size() - wb); end
        if (req_q.size() > rb && req_cyc_q[rb] != g_cyc + 1)
            begin errors++; $display("FAIL grant_latency: request at cycle %0d, required %0d", req_cyc_q[rb], g_cyc + 1); end
        if (withdrawn + hold_err != wd) begin errors++; $display("FAIL grant_req_hold: %0d unstable requests, required 0", withdrawn + hold_err - wd); end
        bus.mem_grant_i = 1'b1;
        wait_idle(200, "grant");
        checks++;
        if (wr_q.size() - wb != FETCH_DEPTH || wr_q[wr_q.size() - 1] !== exp_pkt(exp_addr(base, FETCH_DEPTH - 1)))
            begin errors++; $display("FAIL grant_stream: %0d writes last %h, required %0d last %h", wr_q.size() - wb, wr_q[wr_q.size() - 1], FETCH_DEPTH, exp_pkt(exp_addr(base, FETCH_DEPTH - 1))); end
    endtask

    task automatic test_flush_req();
        int rb, wb, wd, held;
        mem_lat = 3;
        rb = req_q.size(); wb = wr_q.size(); wd = withdrawn;
        pulse_start(28'h0000080);
        wait_read(10, "flush_req");
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        held = 0;
        while (bus.mem_read_o && held < 20) begin held++; step(); end
        checks += 3;
        if (held != mem_lat) begin errors++; $display("FAIL flush_req_hold: request held %0d cycles after flush, required %0d", held, mem_lat); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_req_idle: busy_o=%b after response, required 0", busy_o); end
        if (withdrawn != wd) begin errors++; $display("FAIL flush_req_withdrawn: %0d withdrawn, required 0", withdrawn - wd); end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (wr_q.size() != wb || req_q.size() - rb != 1)
            begin errors++; $display("FAIL flush_req_no_write: %0d writes %0d requests, required 0 and 1", wr_q.size() - wb, req_q.size() - rb); end
    endtask

    task automatic test_flush_write();
        int rb, wb, n;
        mem_lat = 1;
        rb = req_q.size(); wb = wr_q.size();
        pulse_start(28'h0000200);
        n = 0;
        while (!(bus.sb_write_o && wr_q.size() - wb == 1) && n < 100) begin step(); n++; end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks += 2;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_wr_idle: busy_o=%b, required 0", busy_o); end
        for (int i = 0; i < 4; i++) step();
        if (wr_q.size() - wb != 1 || req_q.size() - rb != 2)
            begin errors++; $display("FAIL flush_wr_suppress: %0d writes %0d requests, required 1 and 2", wr_q.size() - wb, req_q.size() - rb); end
    endtask

    task automatic test_restart_wrap();
        int rb, wb, wd;
        logic [ADDR_W-1:0] base1, base2;
        logic [ADDR_W-1:0] exp_r[$];
        base1 = 28'hFFFFFFE;
        base2 = 28'h0000100;
        mem_lat = 2;
        rb = req_q.size(); wb = wr_q.size(); wd = withdrawn;
        pulse_start(base1);
        wait_read(10, "restart");
        pulse_start(base2);
        wait_idle(200, "restart");
        exp_r.push_back(exp_addr(base1, 0));
        for (int i = 0; i < FETCH_DEPTH; i++) exp_r.push_back(exp_addr(base2, i));
        checks += 3;
        if (req_q.size() - rb != exp_r.size()) begin errors++; $display("FAIL restart_req_count: got %0d, required %0d", req_q.size() - rb, exp_r.size()); end
        if (wr_q.size() - wb != FETCH_DEPTH)   begin errors++; $display("FAIL restart_wr_count: got %0d, required %0d", wr_q.size() - wb, FETCH_DEPTH); end
        if (withdrawn != wd) begin errors++; $display("FAIL restart_withdrawn: %0d withdrawn, required 0", withdrawn - wd); end
        for (int i = 0; i < exp_r.size() && rb + i < req_q.size(); i++) begin
            checks++;
            if (req_q[rb + i] !== exp_r[i]) begin errors++; $display("FAIL restart_req_addr[%0d]: got %h, required %h", i, req_q[rb + i], exp_r[i]); end
        end
        for (int i = 0; i < FETCH_DEPTH && wb + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[wb + i] !== exp_pkt(exp_addr(base2, i)))
                begin errors++; $display("FAIL restart_packet[%0d]: got %h, required %h", i, wr_q[wb + i], exp_pkt(exp_addr(base2, i))); end
        end
        // Plain wrap, launched with start and flush together (start wins).
        rb = req_q.size(); wb = wr_q.size();
        flush_i = 1'b1;
        pulse_start(base1);
        flush_i = 1'b0;
        wait_idle(200, "wrap");
        checks += 2;
        if (req_q.size() - rb != FETCH_DEPTH) begin errors++; $display("FAIL wrap_req_count: got %0d, required %0d", req_q.size() - rb, FETCH_DEPTH); end
        if (wr_q.size() - wb != FETCH_DEPTH)  begin errors++; $display("FAIL wrap_wr_count: got %0d, required %0d", wr_q.size() - wb, FETCH_DEPTH); end
        for (int i = 0; i < FETCH_DEPTH && wb + i < wr_q.size() && rb + i < req_q.size(); i++) begin
            checks++;
            if (req_q[rb + i] !== exp_addr(base1, i) || wr_q[wb + i] !== exp_pkt(exp_addr(base1, i)))
                begin errors++; $display("FAIL wrap_block[%0d]: req %h pkt %h, required %h %h", i, req_q[rb + i], wr_q[wb + i], exp_addr(base1, i), exp_pkt(exp_addr(base1, i))); end
        end
    endtask

    task automatic test_random_streams();
        int rb, wb, n;
        logic [ADDR_W-1:0] base;
        for (int it = 0; it < 6; it++) begin
            base = (it % 3 == 0) ? (28'hFFFFFFC + ADDR_W'($urandom_range(3))) : ADDR_W'($urandom);
            mem_lat = $urandom_range(3);
            spur_en = 1'b1;
            rb = req_q.size(); wb = wr_q.size();
            pulse_start(base);
            n = 0;
            while (busy_o && n < 400) begin
                bus.mem_grant_i = ($urandom_range(3) != 0);
                step();
                n++;
            end
            bus.mem_grant_i = 1'b1;
            spur_en = 1'b0;
            step();
            checks += 2;
            if (busy_o !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: busy_o=%b, required 0", it, busy_o); end
            if (req_q.size() - rb != FETCH_DEPTH || wr_q.size() - wb != FETCH_DEPTH)
                begin errors++; $display("FAIL rand%0d_count: %0d requests %0d writes, required %0d each", it, req_q.size() - rb, wr_q.size() - wb, FETCH_DEPTH); end
            for (int i = 0; i < FETCH_DEPTH && wb + i < wr_q.size() && rb + i < req_q.size(); i++) begin
                checks++;
                if (req_q[rb + i] !== exp_addr(base, i) || wr_q[wb + i] !== exp_pkt(exp_addr(base, i)))
                    begin errors++; $display("FAIL rand%0d_block[%0d]: req %h pkt %h, required %h %h", it, i, req_q[rb + i], wr_q[wb + i], exp_addr(base, i), exp_pkt(exp_addr(base, i))); end
            end
        end
    endtask

    task automatic test_async_reset();
        mem_lat = 20;
        pulse_start(28'h0000300);
        wait_read(10, "areset");
        #3 rst_ni = 1'b0;
        #1;
        checks += 4;
        if (bus.mem_read_o !== 1'b0) begin errors++; $display("FAIL areset_mem_read: got %b, required 0", bus.mem_read_o); end
        if (bus.sb_write_o !== 1'b0) begin errors++; $display("FAIL areset_sb_write: got %b, required 0", bus.sb_write_o); end
        if (busy_o !== 1'b0)         begin errors++; $display("FAIL areset_busy: got %b, required 0", busy_o); end
        if (bus.mem_addr_o !== '0)   begin errors++; $display("FAIL areset_mem_addr: got %h, required 0", bus.mem_addr_o); end
        step();
        #2 rst_ni = 1'b1;
        mem_lat = 2;
        step();
        step();
        checks++;
        if (busy_o !== 1'b0 || bus.mem_read_o !== 1'b0)
            begin errors++; $display("FAIL areset_stays_idle: busy_o=%b mem_read_o=%b, required 0 0", busy_o, bus.mem_read_o); end
    endtask

    initial begin
        seed            = $urandom;
        bus.mem_grant_i = 1'b1;
        bus.sb_full_i   = 1'b0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_grant_gating();
        test_flush_req();
        test_flush_write();
        test_restart_wrap();
        test_random_streams();
        test_async_reset();
        checks++;
        if (proto_err != 0) begin errors++; $display("FAIL protocol_total: %0d writes while full, required 0", proto_err); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
